exc_commit: RTL and testbench

Writeback-stage exception/ERTN commit controller for the LA32R pipeline. It takes the retiring instruction's exception flags, the pending-interrupt indication and the ERTN marker, and resolves one trap event by priority. It drives the CSR block's exception-input and ertn interface (`wb_ex`, `wb_ecode`, `wb_esubcode`, `wb_pc`, `ertn_flush`). It then broadcasts a pipeline flush and refetch redirect to the CSR-supplied `ex_entry`, and masks commits while the pipeline drains.

---
 rtl/exc_commit.sv | 151 +++++++++++++++
 tb/tb_exc_commit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit.sv
// Writeback-stage trap resolver: picks one exception or ERTN per retiring
// instruction, pulses the CSR interface, flushes/redirects, then drains.
module exc_commit #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc_adef,
  input  logic        wb_exc_ine,
  input  logic        wb_exc_sys,
  input  logic        wb_exc_brk,
  input  logic        wb_exc_ale,
  input  logic        wb_ertn,
  input  logic        int_pending,
  input  logic [31:0] ex_entry,
  output logic        csr_wb_ex,
  output logic [5:0]  csr_wb_ecode,
  output logic [8:0]  csr_wb_esubcode,
  output logic [31:0] csr_wb_pc,
  output logic        csr_ertn_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        commit_ok,
  output logic [15:0] ex_count
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [3:0] DRAIN_LD   = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ertn_q, ertn_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] ex_count_q, ex_count_d;

  logic        exc_hit;
  logic [5:0]  sel_ecode;
  logic        in_trap;

  // Interrupt outranks every synchronous exception; ERTN only if nothing else.
  always_comb begin
    exc_hit   = int_pending | wb_exc_adef | wb_exc_ine | wb_exc_sys
              | wb_exc_brk | wb_exc_ale;
    sel_ecode = ECODE_ALE;
    if (int_pending)      sel_ecode = ECODE_INT;
    else if (wb_exc_adef) sel_ecode = ECODE_ADEF;
    else if (wb_exc_ine)  sel_ecode = ECODE_INE;
    else if (wb_exc_sys)  sel_ecode = ECODE_SYS;
    else if (wb_exc_brk)  sel_ecode = ECODE_BRK;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ertn_d     = ertn_q;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    pc_d       = pc_q;
    ex_count_d = ex_count_q;
    commit_ok  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_valid) begin
          if (exc_hit) begin
            ertn_d  = 1'b0;
            ecode_d = sel_ecode;
            esub_d  = 9'd0;
            pc_d    = wb_pc;
            if (ex_count_q != 16'hFFFF) ex_count_d = ex_count_q + 16'd1;
            state_d = S_TRAP;
          end else if (wb_ertn) begin
            ertn_d  = 1'b1;
            state_d = S_TRAP;
          end else begin
            commit_ok = 1'b1;
          end
        end
      end
      S_TRAP: begin
        if (DRAIN_LD == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        // Exit on the count-of-1 cycle so the next trap lands at N+2+DRAIN.
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ertn_q     <= 1'b0;
      ecode_q    <= 6'd0;
      esub_q     <= 9'd0;
      pc_q       <= 32'd0;
      ex_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ertn_q     <= ertn_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      pc_q       <= pc_d;
      ex_count_q <= ex_count_d;
    end
  end

  assign in_trap         = (state_q == S_TRAP);
  assign csr_wb_ex       = in_trap & ~ertn_q;
  assign csr_ertn_flush  = in_trap & ertn_q;
  assign pipe_flush      = in_trap;
  assign redirect_valid  = in_trap;
  assign redirect_pc     = in_trap ? ex_entry : 32'd0;
  assign csr_wb_ecode    = ecode_q;
  assign csr_wb_esubcode = esub_q;
  assign csr_wb_pc       = pc_q;
  assign ex_count        = ex_count_q;

endmodule

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: stimulus queues expected trap pulses,
// a negedge monitor pops and compares them whenever a redirect appears.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale;
  logic        wb_ertn;
  logic        int_pending;
  logic [31:0] ex_entry;
  logic        csr_wb_ex;
  logic [5:0]  csr_wb_ecode;
  logic [8:0]  csr_wb_esubcode;
  logic [31:0] csr_wb_pc;
  logic        csr_ertn_flush;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        commit_ok;
  logic [15:0] ex_count;

  always #5 clk = ~clk;

  exc_commit #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
    .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn),
    .int_pending(int_pending), .ex_entry(ex_entry),
    .csr_wb_ex(csr_wb_ex), .csr_wb_ecode(csr_wb_ecode),
    .csr_wb_esubcode(csr_wb_esubcode), .csr_wb_pc(csr_wb_pc),
    .csr_ertn_flush(csr_ertn_flush), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_ok(commit_ok), .ex_count(ex_count)
  );

  typedef struct {
    logic        ertn;
    logic [5:0]  ecode;
    logic [31:0] pc;
    logic [31:0] tgt;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    wb_valid = 1'b0;
    {wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale} = 5'b0;
    wb_ertn = 1'b0;
    int_pending = 1'b0;
  endtask

  // exc bits: {adef, ine, sys, brk, ale}
  task automatic trap(input logic [4:0] exc, input logic ertn, input logic intp,
                      input logic [31:0] pc, input logic [31:0] entry,
                      input logic exp_ertn, input logic [5:0] exp_ecode, input string tag);
    exp_t e;
    wb_valid = 1'b1;
    {wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale} = exc;
    wb_ertn = ertn;
    int_pending = intp;
    wb_pc = pc;
    ex_entry = entry;
    e.ertn = exp_ertn; e.ecode = exp_ecode; e.pc = pc; e.tgt = entry; e.tag = tag;
    exp_q.push_back(e);
    if (!exp_ertn && exp_cnt != 16'hFFFF) exp_cnt++;
    #1 chk({tag, " commit_ok at N"}, 32'(commit_ok), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      quiet_inputs();
      wb_valid = 1'b1;
      #1 chk({tag, " commit_ok masked"}, 32'(commit_ok), 32'd0);
    end
    step();
    #1 chk({tag, " commit_ok at N+5"}, 32'(commit_ok), 32'd1);
    chk({tag, " ex_count"}, 32'(ex_count), 32'(exp_cnt));
    $display("trap %s pc=0x%08h ex_count=0x%04h", tag, pc, ex_count);
    quiet_inputs();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected redirect", 32'(redirect_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.tag, " csr_wb_ex"}, 32'(csr_wb_ex), 32'(!e.ertn));
          chk({e.tag, " csr_ertn_flush"}, 32'(csr_ertn_flush), 32'(e.ertn));
          chk({e.tag, " pipe_flush"}, 32'(pipe_flush), 32'd1);
          chk({e.tag, " redirect_pc"}, redirect_pc, e.tgt);
          if (!e.ertn) begin
            chk({e.tag, " ecode"}, 32'(csr_wb_ecode), 32'(e.ecode));
            chk({e.tag, " esubcode"}, 32'(csr_wb_esubcode), 32'd0);
            chk({e.tag, " csr_wb_pc"}, csr_wb_pc, e.pc);
          end
        end
      end else begin
        chk("idle pulses", 32'({csr_wb_ex, csr_ertn_flush, pipe_flush}), 32'd0);
        chk("idle redirect_pc", redirect_pc, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wb_pc = 32'd0;
    ex_entry = 32'h1C008000;
    quiet_inputs();
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("reset ex_count", 32'(ex_count), 32'd0);
    chk("reset ecode", 32'(csr_wb_ecode), 32'd0);
    chk("reset csr_wb_pc", csr_wb_pc, 32'd0);
    chk("reset commit_ok", 32'(commit_ok), 32'd0);

    wb_valid = 1'b1;
    wb_pc = 32'h1C0000F0;
    #1 chk("clean commit_ok", 32'(commit_ok), 32'd1);
    step();
    quiet_inputs();

    trap(5'b00100, 1'b0, 1'b0, 32'h1C000100, 32'h1C008000, 1'b0, 6'h0B, "syscall");
    trap(5'b11001, 1'b0, 1'b0, 32'h1C000104, 32'h1C008000, 1'b0, 6'h08, "adef_ine_ale");

    int_pending = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("int no valid commit_ok", 32'(commit_ok), 32'd0);
      step();
    end
    #1 chk("int no valid ex_count", 32'(ex_count), 32'(exp_cnt));
    quiet_inputs();

    trap(5'b00001, 1'b0, 1'b1, 32'h1C000108, 32'h1C008000, 1'b0, 6'h00, "int_ale");
    trap(5'b00000, 1'b1, 1'b0, 32'h1C000200, 32'h1C000050, 1'b1, 6'h00, "ertn");
    trap(5'b00010, 1'b1, 1'b0, 32'h1C000204, 32'h1C008000, 1'b0, 6'h0C, "ertn_brk");
    trap(5'b01000, 1'b0, 1'b0, 32'h1C000208, 32'h1C008000, 1'b0, 6'h0D, "ine");
    trap(5'b00001, 1'b0, 1'b0, 32'h1C00020C, 32'h1C008000, 1'b0, 6'h09, "ale");

    // Reset while draining a syscall trap
    begin
      exp_t e;
      wb_valid = 1'b1;
      wb_exc_sys = 1'b1;
      wb_pc = 32'h1C000300;
      e.ertn = 1'b0; e.ecode = 6'h0B; e.pc = 32'h1C000300; e.tgt = ex_entry; e.tag = "sys_before_reset";
      exp_q.push_back(e);
      step();
      quiet_inputs();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_cnt = 16'd0;
      #1;
      chk("mid-drain reset ex_count", 32'(ex_count), 32'd0);
      chk("mid-drain reset ecode", 32'(csr_wb_ecode), 32'd0);
      chk("mid-drain reset csr_wb_pc", csr_wb_pc, 32'd0);
      wb_valid = 1'b1;
      #1 chk("after reset commit_ok", 32'(commit_ok), 32'd1);
      $display("reset during drain ex_count=0x%04h", ex_count);
      step();
      quiet_inputs();
    end

    // Preload the counter close to saturation, then walk it over the top
    force dut.ex_count_q = 16'hFFFD;
    #1;
    release dut.ex_count_q;
    exp_cnt = 16'hFFFD;
    #1 chk("preload ex_count", 32'(ex_count), 32'hFFFD);
    trap(5'b00010, 1'b0, 1'b0, 32'h1C000400, 32'h1C008000, 1'b0, 6'h0C, "brk_fffe");
    trap(5'b00010, 1'b0, 1'b0, 32'h1C000404, 32'h1C008000, 1'b0, 6'h0C, "brk_ffff");
    trap(5'b00010, 1'b0, 1'b0, 32'h1C000408, 32'h1C008000, 1'b0, 6'h0C, "brk_sat");

    step();
    step();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
